// File: rtl/dmem_ctrl.sv
// Handshaked RV32I data memory: byte-lane stores, sign/zero-extended loads, RD_LAT-cycle response.
// Define DMEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of silently aligning them.
module dmem_ctrl #(
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned RD_LAT    = 1,
  parameter string       INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);
  localparam int unsigned DEPTH = 1 << (ADDR_W - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic [2:0]        cnt;
  logic [31:0]       mem [DEPTH];
  logic [31:0]       rd_word;
  logic [1:0]        lane_q;
  logic [2:0]        funct3_q;
  logic              we_q;
  logic              err_q;

  logic              accept;
  logic              illegal;
  logic              err;
  logic              wr_en;
  logic [ADDR_W-1:0] addr_eff;
  logic [3:0]        be;
  logic [31:0]       wdata_rep;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_val;

  always_comb begin
    accept  = req_valid & req_ready;
    illegal = req_we ? (req_funct3 > 3'd2)
                     : (req_funct3 == 3'd3 || req_funct3[2:1] == 2'b11);
    addr_eff = req_addr;
`ifdef DMEM_MISALIGN_TRAP_EN
    err = illegal
        | ((req_funct3[1:0] == 2'b01) & req_addr[0])
        | ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
`else
    err = illegal;
    if (req_funct3[1:0] == 2'b01) addr_eff[0]   = 1'b0;
    if (req_funct3[1:0] == 2'b10) addr_eff[1:0] = 2'b00;
`endif
    wr_en = accept & req_we & ~err;
    case (req_funct3[1:0])
      2'b00: begin
        be        = 4'b0001 << addr_eff[1:0];
        wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be        = addr_eff[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      default: begin
        be        = '1;
        wdata_rep = req_wdata;
      end
    endcase
  end

  // Array has no reset so it survives rst_n; the read port samples the pre-write word.
  always_ff @(posedge clk) begin
    if (accept) rd_word <= mem[addr_eff[ADDR_W-1:2]];
    if (wr_en) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (be[k]) mem[addr_eff[ADDR_W-1:2]][8*k +: 8] <= wdata_rep[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      lane_q   <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lane_q   <= addr_eff[1:0];
            funct3_q <= req_funct3;
            we_q     <= req_we;
            err_q    <= err;
            if (RD_LAT <= 1) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= 3'(RD_LAT - 1);
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt <= 3'd1) state <= RESP;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    byte_sel = rd_word[{lane_q, 3'b000} +: 8];
    half_sel = lane_q[1] ? rd_word[31:16] : rd_word[15:0];
    case (funct3_q)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_val = rd_word;
      3'b100:  load_val = {24'h0, byte_sel};
      3'b101:  load_val = {16'h0, half_sel};
      default: load_val = '0;
    endcase
    req_ready = (state == IDLE);
    busy      = (state != IDLE);
    rsp_valid = (state == RESP);
    rsp_err   = rsp_valid & err_q;
    rsp_rdata = (rsp_valid & ~we_q & ~err_q) ? load_val : '0;
  end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: two instances (RD_LAT 1 and 3) against a byte-array reference model.
module tb_dmem_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        rv1, rv3;
    logic        req_we;
    logic [2:0]  f3;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic        rsp_ready;
    logic        rr1, rr3, vld1, vld3, er1, er3, busy1, busy3;
    logic [31:0] rd1, rd3;

    int tests_run = 0;
    int fails = 0;
    bit [7:0] mm [2][512];

    typedef struct packed {
        bit        we;
        bit [2:0]  f;
        bit [8:0]  a;
        bit [31:0] wd;
        bit        cc;
        bit [31:0] cv;
    } op_t;

    always #5 clk = ~clk;

    dmem_ctrl #(.ADDR_W(9), .RD_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv1), .req_ready(rr1), .req_we(req_we),
        .req_funct3(f3), .req_addr(addr), .req_wdata(wdata), .rsp_valid(vld1),
        .rsp_ready(rsp_ready), .rsp_rdata(rd1), .rsp_err(er1), .busy(busy1)
    );

    dmem_ctrl #(.ADDR_W(9), .RD_LAT(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv3), .req_ready(rr3), .req_we(req_we),
        .req_funct3(f3), .req_addr(addr), .req_wdata(wdata), .rsp_valid(vld3),
        .rsp_ready(rsp_ready), .rsp_rdata(rd3), .rsp_err(er3), .busy(busy3)
    );

    // Reference: byte-addressed memory, access size 2**funct3[1:0] bytes, arithmetic sign extension.
    function automatic void model(input int s, input bit we, input bit [2:0] f, input bit [8:0] a,
                                  input bit [31:0] wd, output bit [31:0] rd, output bit err);
        int     size;
        int     base;
        longint v;
        bit     illegal;
        rd = 0;
        err = 0;
        illegal = we ? (f > 2) : (f == 3 || f == 6 || f == 7);
        if (illegal) begin
            err = 1;
            return;
        end
        size = 1 << f[1:0];
        base = int'(a);
`ifdef DMEM_MISALIGN_TRAP_EN
        if (base % size != 0) begin
            err = 1;
            return;
        end
`else
        base = base - (base % size);
`endif
        if (we) begin
            for (int i = 0; i < size; i++) mm[s][base + i] = wd[8*i +: 8];
        end else begin
            v = 0;
            for (int i = 0; i < size; i++) v += longint'(mm[s][base + i]) << (8 * i);
            if (!f[2] && size < 4 && v >= (longint'(1) << (8 * size - 1)))
                v -= longint'(1) << (8 * size);
            rd = v[31:0];
        end
    endfunction

    function automatic logic vld_of(input int s);
        return s != 0 ? vld3 : vld1;
    endfunction

    // Issues one request from IDLE and consumes its response; lat = edges from accept to rsp_valid.
    task automatic do_req(input int s, input bit we, input bit [2:0] f, input bit [8:0] a,
                          input bit [31:0] wd, output logic [31:0] rd, output logic err,
                          output int lat);
        req_we = we;
        f3 = f;
        addr = a;
        wdata = wd;
        rsp_ready = 1'b0;
        if (s != 0) rv3 = 1'b1; else rv1 = 1'b1;
        @(posedge clk); #1;
        rv1 = 1'b0;
        rv3 = 1'b0;
        lat = 1;
        while (!vld_of(s) && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!vld_of(s)) lat = 99;
        rd  = (s != 0) ? rd3 : rd1;
        err = (s != 0) ? er3 : er1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        tests_run++;
        if ({rr1, vld1, rd1, er1, busy1} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_lat1 got ready=%b valid=%b rdata=%h err=%b busy=%b want 1 0 0 0 0",
                     rr1, vld1, rd1, er1, busy1);
        end
        tests_run++;
        if ({rr3, vld3, rd3, er3, busy3} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_lat3 got ready=%b valid=%b rdata=%h err=%b busy=%b want 1 0 0 0 0",
                     rr3, vld3, rd3, er3, busy3);
        end
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic fill_memory;
        logic [31:0] rd;
        logic        err;
        bit   [31:0] erd;
        bit          eerr;
        int          lat;
        bit   [31:0] wd;
        for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < 128; w++) begin
                wd = $urandom;
                model(s, 1'b1, 3'd2, 9'(w * 4), wd, erd, eerr);
                do_req(s, 1'b1, 3'd2, 9'(w * 4), wd, rd, err, lat);
            end
        end
    endtask

    task automatic test_basic;
        op_t ops[2];
        logic [31:0] rd;
        logic        err;
        bit   [31:0] erd;
        bit          eerr;
        int          lat;
        ops[0] = '{1'b1, 3'd2, 9'h010, 32'hDEADBEEF, 1'b1, 32'h0};
        ops[1] = '{1'b0, 3'd2, 9'h010, 32'h0,        1'b1, 32'hDEADBEEF};
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 2; i++) begin
                model(s, ops[i].we, ops[i].f, ops[i].a, ops[i].wd, erd, eerr);
                if (ops[i].cc) erd = ops[i].cv;
                do_req(s, ops[i].we, ops[i].f, ops[i].a, ops[i].wd, rd, err, lat);
                tests_run++;
                if (rd !== erd || err !== eerr || lat != (s != 0 ? 3 : 1)) begin
                    fails++;
                    $display("FAIL basic[%0d] inst=%0d got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=%0d",
                             i, s, rd, err, lat, erd, eerr, s != 0 ? 3 : 1);
                end
            end
        end
    endtask

    task automatic test_byte_half;
        op_t ops[8];
        logic [31:0] rd;
        logic        err;
        bit   [31:0] erd;
        bit          eerr;
        int          lat;
        ops[0] = '{1'b1, 3'd0, 9'h021, 32'h12345680, 1'b1, 32'h0};
        ops[1] = '{1'b0, 3'd0, 9'h021, 32'h0,        1'b1, 32'hFFFFFF80};
        ops[2] = '{1'b0, 3'd4, 9'h021, 32'h0,        1'b1, 32'h00000080};
        ops[3] = '{1'b0, 3'd2, 9'h020, 32'h0,        1'b0, 32'h0};
        ops[4] = '{1'b1, 3'd1, 9'h032, 32'hABCD8001, 1'b1, 32'h0};
        ops[5] = '{1'b0, 3'd1, 9'h032, 32'h0,        1'b1, 32'hFFFF8001};
        ops[6] = '{1'b0, 3'd5, 9'h032, 32'h0,        1'b1, 32'h00008001};
        ops[7] = '{1'b0, 3'd2, 9'h030, 32'h0,        1'b0, 32'h0};
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 8; i++) begin
                model(s, ops[i].we, ops[i].f, ops[i].a, ops[i].wd, erd, eerr);
                if (ops[i].cc) erd = ops[i].cv;
                do_req(s, ops[i].we, ops[i].f, ops[i].a, ops[i].wd, rd, err, lat);
                tests_run++;
                if (rd !== erd || err !== eerr || lat != (s != 0 ? 3 : 1)) begin
                    fails++;
                    $display("FAIL byte_half[%0d] inst=%0d got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=%0d",
                             i, s, rd, err, lat, erd, eerr, s != 0 ? 3 : 1);
                end
            end
        end
    endtask

    task automatic test_hold;
        bit   [31:0] erd;
        bit          eerr;
        logic [31:0] held;
        int          lat;
        model(1, 1'b0, 3'd2, 9'h010, 32'h0, erd, eerr);
        req_we = 1'b0; f3 = 3'd2; addr = 9'h010; rsp_ready = 1'b0; rv3 = 1'b1;
        @(posedge clk); #1;
        rv3 = 1'b0;
        lat = 1;
        while (!vld3 && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        held = rd3;
        tests_run++;
        if (lat != 3 || held !== erd || er3 !== 1'b0) begin
            fails++;
            $display("FAIL hold_first lat=%0d rdata=%h err=%b want lat=3 rdata=%h err=0", lat, held, er3, erd);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            tests_run++;
            if (vld3 !== 1'b1 || rd3 !== held || rr3 !== 1'b0) begin
                fails++;
                $display("FAIL hold_cycle%0d valid=%b rdata=%h ready=%b want 1 %h 0", c, vld3, rd3, rr3, held);
            end
        end
        // Response taken while a new request is already waiting: it must not be accepted this edge.
        model(1, 1'b0, 3'd2, 9'h020, 32'h0, erd, eerr);
        rsp_ready = 1'b1; addr = 9'h020; rv3 = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        tests_run++;
        if (vld3 !== 1'b0 || rr3 !== 1'b1 || busy3 !== 1'b0) begin
            fails++;
            $display("FAIL hold_release valid=%b ready=%b busy=%b want 0 1 0", vld3, rr3, busy3);
        end
        @(posedge clk); #1;
        rv3 = 1'b0;
        tests_run++;
        if (busy3 !== 1'b1 || rr3 !== 1'b0) begin
            fails++;
            $display("FAIL hold_next_accept busy=%b ready=%b want 1 0", busy3, rr3);
        end
        lat = 1;
        while (!vld3 && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        tests_run++;
        if (lat != 3 || rd3 !== erd || er3 !== 1'b0) begin
            fails++;
            $display("FAIL hold_second lat=%0d rdata=%h err=%b want lat=3 rdata=%h err=0", lat, rd3, er3, erd);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_misalign;
        op_t ops[7];
        logic [31:0] rd;
        logic        err;
        bit   [31:0] erd;
        bit          eerr;
        int          lat;
        ops[0] = '{1'b0, 3'd2, 9'h013, 32'h0,        1'b0, 32'h0};
        ops[1] = '{1'b1, 3'd3, 9'h010, 32'h12345678, 1'b0, 32'h0};
        ops[2] = '{1'b0, 3'd2, 9'h010, 32'h0,        1'b0, 32'h0};
        ops[3] = '{1'b1, 3'd1, 9'h031, 32'h0000A5A5, 1'b0, 32'h0};
        ops[4] = '{1'b0, 3'd5, 9'h033, 32'h0,        1'b0, 32'h0};
        ops[5] = '{1'b0, 3'd6, 9'h000, 32'h0,        1'b0, 32'h0};
        ops[6] = '{1'b1, 3'd2, 9'h046, 32'h13572468, 1'b0, 32'h0};
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 7; i++) begin
                model(s, ops[i].we, ops[i].f, ops[i].a, ops[i].wd, erd, eerr);
                do_req(s, ops[i].we, ops[i].f, ops[i].a, ops[i].wd, rd, err, lat);
                tests_run++;
                if (rd !== erd || err !== eerr || lat != (s != 0 ? 3 : 1)) begin
                    fails++;
                    $display("FAIL misalign[%0d] inst=%0d got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=%0d",
                             i, s, rd, err, lat, erd, eerr, s != 0 ? 3 : 1);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd;
        logic        err;
        bit   [31:0] erd;
        bit          eerr;
        int          lat;
        bit          stale;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) model(1, 1'b1, 3'd2, 9'h040, 32'hCAFEF00D, erd, eerr);
            req_we = (k == 0); f3 = 3'd2; addr = (k == 0) ? 9'h040 : 9'h044;
            wdata = 32'hCAFEF00D; rsp_ready = 1'b0; rv3 = 1'b1;
            @(posedge clk); #1;
            rv3 = 1'b0;
            #1 rst_n = 1'b0;
            #1;
            tests_run++;
            if (vld3 !== 1'b0 || rr3 !== 1'b1 || busy3 !== 1'b0) begin
                fails++;
                $display("FAIL reset_mid%0d valid=%b ready=%b busy=%b want 0 1 0", k, vld3, rr3, busy3);
            end
            #2 rst_n = 1'b1;
            stale = 1'b0;
            for (int c = 0; c < 6; c++) begin
                @(posedge clk); #1;
                if (vld3 !== 1'b0 || busy3 !== 1'b0) stale = 1'b1;
            end
            tests_run++;
            if (stale) begin
                fails++;
                $display("FAIL reset_stale%0d stale response or busy seen after release, want none", k);
            end
        end
        model(1, 1'b0, 3'd2, 9'h040, 32'h0, erd, eerr);
        do_req(1, 1'b0, 3'd2, 9'h040, 32'h0, rd, err, lat);
        tests_run++;
        if (rd !== 32'hCAFEF00D || rd !== erd || err !== 1'b0 || lat != 3) begin
            fails++;
            $display("FAIL reset_store_kept got rdata=%h err=%b lat=%0d want rdata=cafef00d err=0 lat=3",
                     rd, err, lat);
        end
    endtask

    task automatic test_random;
        logic [31:0] rd;
        logic        err;
        bit   [31:0] erd;
        bit          eerr;
        int          lat;
        int          s;
        bit          we;
        bit   [2:0]  f;
        bit   [8:0]  a;
        bit   [31:0] wd;
        for (int i = 0; i < 300; i++) begin
            s  = int'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            f  = 3'($urandom_range(0, 7));
            a  = 9'($urandom_range(0, 511));
            wd = $urandom;
            model(s, we, f, a, wd, erd, eerr);
            do_req(s, we, f, a, wd, rd, err, lat);
            tests_run++;
            if (rd !== erd || err !== eerr || lat != (s != 0 ? 3 : 1)) begin
                fails++;
                $display("FAIL random[%0d] inst=%0d we=%0d f3=%0d addr=%h got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=%0d",
                         i, s, we, f, a, rd, err, lat, erd, eerr, s != 0 ? 3 : 1);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rv1 = 1'b0; rv3 = 1'b0; req_we = 1'b0; f3 = '0; addr = '0; wdata = '0; rsp_ready = 1'b0;
        test_reset;
        fill_memory;
        test_basic;
        test_byte_half;
        test_hold;
        test_misalign;
        test_reset_mid;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
